// File: rtl/fetch_stream_buffer.sv
// Sequential instruction-fetch stream buffer: two 64-byte line slots feeding a decoder window.
// Optional statistics counters are enabled with `define FETCH_STREAM_STATS_EN.
module fetch_stream_buffer #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned WINDOW_BYTES = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_valid,
    input  logic [ADDR_WIDTH-1:0]              start_addr,
    output logic                               mem_req_valid,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr,
    input  logic                               mem_req_ready,
    input  logic                               line_valid,
    input  logic [511:0]                       line_data,
    output logic                               dec_valid,
    output logic [WINDOW_BYTES*8-1:0]          dec_bytes,
    output logic [$clog2(WINDOW_BYTES):0]      dec_avail,
    output logic [ADDR_WIDTH-1:0]              dec_pc,
    input  logic [$clog2(WINDOW_BYTES):0]      dec_consume
`ifdef FETCH_STREAM_STATS_EN
    ,
    output logic [31:0]                        stat_lines,
    output logic [15:0]                        stat_drops,
    output logic [31:0]                        stat_starve
`endif
);

    localparam int unsigned CW = $clog2(WINDOW_BYTES) + 1;
    localparam logic [7:0] WinMax = 8'(WINDOW_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LineStep = ADDR_WIDTH'(64);

    typedef enum logic [2:0] {
        StOff,
        StReq,
        StWait,
        StWaitDrop,
        StFull
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [6:0]              rd_ptr_q, rd_ptr_d;
    logic [5:0]              skip_q, skip_d;
    logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [511:0]            slot_q [2];

    logic [7:0]              avail8;
    logic [7:0]              consume_ext;
    logic [7:0]              cons;
    logic [6:0]              wr_ptr;
    logic                    wr_en;
    logic [1023:0]           ring;

    assign avail8      = (cnt_q < WinMax) ? cnt_q : WinMax;
    assign consume_ext = 8'(dec_consume);
    // Over-consumption is a protocol error; clamp so the ring state stays consistent.
    assign cons        = (consume_ext > avail8) ? avail8 : consume_ext;
    assign wr_ptr      = rd_ptr_q + cnt_q[6:0];
    assign ring        = {slot_q[1], slot_q[0]};

    assign mem_req_valid = (state_q == StReq);
    assign mem_req_addr  = fill_q;
    assign dec_valid     = (cnt_q != 8'd0);
    assign dec_avail     = avail8[CW-1:0];
    assign dec_pc        = pc_q;

    // Bytes past dec_avail are forced to zero so the window is deterministic out of reset.
    always_comb begin
        dec_bytes = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            if (8'(i) < avail8) begin
                dec_bytes[i*8 +: 8] = ring[{rd_ptr_q + 7'(i), 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q - cons;
        rd_ptr_d = rd_ptr_q + cons[6:0];
        pc_d     = pc_q + ADDR_WIDTH'(cons);
        fill_d   = fill_q;
        skip_d   = skip_q;
        wr_en    = 1'b0;

        case (state_q)
            StReq: begin
                if (mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (line_valid) begin
                    wr_en   = 1'b1;
                    cnt_d   = cnt_q + (8'd64 - 8'(skip_q)) - cons;
                    skip_d  = 6'd0;
                    fill_d  = fill_q + LineStep;
                    state_d = (cnt_d <= 8'd64) ? StReq : StFull;
                end
            end
            StWaitDrop: begin
                if (line_valid) begin
                    state_d = StReq;
                end
            end
            StFull: begin
                if (cnt_d <= 8'd64) begin
                    state_d = StReq;
                end
            end
            default: begin
            end
        endcase

        if (start_valid) begin
            wr_en    = 1'b0;
            cnt_d    = 8'd0;
            rd_ptr_d = {1'b0, start_addr[5:0]};
            skip_d   = start_addr[5:0];
            pc_d     = start_addr;
            fill_d   = {start_addr[ADDR_WIDTH-1:6], 6'b000000};
            // A line still in flight from the old stream must be swallowed.
            state_d  = (state_q == StWait && !line_valid) ? StWaitDrop : StReq;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StOff;
            cnt_q    <= 8'd0;
            rd_ptr_q <= 7'd0;
            skip_q   <= 6'd0;
            fill_q   <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            skip_q   <= skip_d;
            fill_q   <= fill_d;
            pc_q     <= pc_d;
        end
    end

    // Write pointer is slot-aligned (or inside slot 0 before the first line), so bit 6 picks the slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot_q[wr_ptr[6]] <= line_data;
        end
    end

`ifdef FETCH_STREAM_STATS_EN
    logic drop_ev;
    assign drop_ev = line_valid &&
                     ((state_q == StWaitDrop) || (state_q == StWait && start_valid));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lines  <= 32'd0;
            stat_drops  <= 16'd0;
            stat_starve <= 32'd0;
        end else begin
            if (wr_en && stat_lines != 32'hffff_ffff) begin
                stat_lines <= stat_lines + 32'd1;
            end
            if (drop_ev && stat_drops != 16'hffff) begin
                stat_drops <= stat_drops + 16'd1;
            end
            if (state_q == StWait && cnt_q == 8'd0 && stat_starve != 32'hffff_ffff) begin
                stat_starve <= stat_starve + 32'd1;
            end
        end
    end
`endif

    line_valid_in_wait_a: assert property (@(posedge clk) disable iff (!reset)
        line_valid |-> (state_q == StWait || state_q == StWaitDrop))
        else $error("line_valid outside WAIT/WAIT_DROP");

    consume_le_avail_a: assert property (@(posedge clk) disable iff (!reset)
        !start_valid |-> (consume_ext <= avail8))
        else $error("dec_consume exceeds dec_avail");

endmodule

// File: tb/tb_fetch_stream_buffer.sv
// Randomized bench for fetch_stream_buffer against a byte-stream reference model.
// Memory content is a pure function of address, so the window is predicted from dec_pc alone.
module tb_fetch_stream_buffer;
    localparam int AW = 64;
    localparam int WB = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_valid = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ready = 1'b0;
    logic          line_valid = 1'b0;
    logic [511:0]  line_data = '0;
    logic          dec_valid;
    logic [WB*8-1:0] dec_bytes;
    logic [CW-1:0] dec_avail;
    logic [AW-1:0] dec_pc;
    logic [CW-1:0] dec_consume = '0;
`ifdef FETCH_STREAM_STATS_EN
    logic [31:0]   stat_lines;
    logic [15:0]   stat_drops;
    logic [31:0]   stat_starve;
`endif

    fetch_stream_buffer #(.ADDR_WIDTH(AW), .WINDOW_BYTES(WB)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_addr   (start_addr),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .line_valid   (line_valid),
        .line_data    (line_data),
        .dec_valid    (dec_valid),
        .dec_bytes    (dec_bytes),
        .dec_avail    (dec_avail),
        .dec_pc       (dec_pc),
        .dec_consume  (dec_consume)
`ifdef FETCH_STREAM_STATS_EN
        ,
        .stat_lines   (stat_lines),
        .stat_drops   (stat_drops),
        .stat_starve  (stat_starve)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stream of valid bytes starting at m_pc, plus one outstanding line.
    bit          m_on, m_out, m_drop;
    int          m_cnt, m_skip, mem_delay, max_delay, forced_delay;
    logic [AW-1:0] m_pc, m_fill, m_line_addr;
    int          m_lines, m_drops, m_starve;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ a[39:32];
    endfunction

    function automatic int m_avail();
        return (m_cnt < WB) ? m_cnt : WB;
    endfunction

    task automatic model_reset();
        m_on = 0; m_out = 0; m_drop = 0;
        m_cnt = 0; m_skip = 0; mem_delay = 0;
        m_pc = '0; m_fill = '0; m_line_addr = '0;
        m_lines = 0; m_drops = 0; m_starve = 0;
    endtask

    task automatic check_outputs();
        bit exp_req;
        logic [WB*8-1:0] exp_win, mask;
        exp_req = m_on && !m_out && (m_cnt <= 64);
        check_eq("req_valid", mem_req_valid, exp_req);
        if (exp_req) check_eq("req_addr", mem_req_addr, m_fill);
        check_eq("dec_valid", dec_valid, m_cnt != 0);
        check_eq("dec_avail", dec_avail, m_avail());
        check_eq("dec_pc", dec_pc, m_pc);
        exp_win = '0;
        mask = '0;
        for (int i = 0; i < m_avail(); i++) begin
            exp_win[i*8 +: 8] = mem_byte(m_pc + AW'(i));
            mask[i*8 +: 8] = 8'hff;
        end
        check_eq("dec_bytes", dec_bytes & mask, exp_win);
`ifdef FETCH_STREAM_STATS_EN
        check_eq("stat_lines", stat_lines, m_lines);
        check_eq("stat_drops", stat_drops, m_drops);
        check_eq("stat_starve", stat_starve, m_starve);
`endif
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model, then check at next negedge.
    task automatic step(input bit sv_in, input logic [AW-1:0] sa, input bit rdy_in, input int c_in);
        bit sv, rdy, lv, pre_req;
        int c;
        lv  = m_out && (mem_delay == 0);
        sv  = sv_in && !(m_drop && !lv);
        rdy = rdy_in && !sv;
        c   = (c_in > m_avail()) ? m_avail() : c_in;
        start_valid   = sv;
        start_addr    = sa;
        mem_req_ready = rdy;
        line_valid    = lv;
        dec_consume   = CW'(c);
        for (int i = 0; i < 64; i++)
            line_data[8*i +: 8] = lv ? mem_byte(m_line_addr + AW'(i)) : 8'h00;

        pre_req = m_on && !m_out && (m_cnt <= 64);
        if (m_out && !m_drop && m_cnt == 0) m_starve++;
        if (m_out && !lv && mem_delay > 0) mem_delay--;
        if (sv) begin
            if (lv) begin
                m_out = 0; m_drop = 0; m_drops++;
            end else if (m_out) begin
                m_drop = 1;
            end
            m_cnt = 0;
            m_pc = sa;
            m_skip = int'(sa[5:0]);
            m_fill = {sa[AW-1:6], 6'b0};
            m_on = 1;
        end else begin
            m_cnt -= c;
            m_pc += AW'(c);
            if (lv) begin
                m_out = 0;
                if (m_drop) begin
                    m_drop = 0; m_drops++;
                end else begin
                    m_cnt += 64 - m_skip;
                    m_skip = 0;
                    m_fill += AW'(64);
                    m_lines++;
                end
            end
            if (pre_req && rdy) begin
                m_out = 1;
                m_line_addr = m_fill;
                if (forced_delay >= 0) begin
                    mem_delay = forced_delay;
                    forced_delay = -1;
                end else begin
                    mem_delay = $urandom_range(max_delay, 0);
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int c;
        bit sv;
        logic [AW-1:0] sa;
        model_reset();
        max_delay = 0;
        forced_delay = -1;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b1;
        @(negedge clk);
        check_outputs();

        // Aligned start, no consumption: two lines fill the ring, then no further request
        step(1, 64'h1000, 1, 0);
        check_eq("first_req", mem_req_addr, 64'h1000);
        repeat (12) step(0, '0, 1, 0);
        check_eq("full_avail", dec_avail, 16);
        check_eq("full_no_req", mem_req_valid, 1'b0);
        check_eq("full_pc", dec_pc, 64'h1000);

        // Unaligned start: first line contributes only its tail
        step(1, 64'h2035, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        check_eq("skip_avail", dec_avail, 11);
        check_eq("skip_pc", dec_pc, 64'h2035);
        check_eq("skip_next_req", mem_req_addr, 64'h2040);
        repeat (6) step(0, '0, 1, 0);

        // Redirect while a line is in flight: that line must be dropped
        step(1, 64'h5000, 1, 0);
        forced_delay = 2;
        step(0, '0, 1, 0);
        step(1, 64'h3000, 0, 0);
        repeat (8) step(0, '0, 1, 0);
        check_eq("redir_pc", dec_pc, 64'h3000);

        // Asynchronous reset mid-WAIT with line_valid pulsing
        step(1, 64'h7000, 1, 0);
        forced_delay = 5;
        step(0, '0, 1, 0);
        #2 reset = 1'b0;
        line_valid = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_bytes", dec_bytes, '0);
        @(negedge clk);
        line_valid = 1'b0;
        check_outputs();
        reset = 1'b1;
        repeat (4) step(0, '0, 1, 0);

        // Random traffic
        max_delay = 3;
        for (int n = 0; n < 4000; n++) begin
            sv = ($urandom_range(39, 0) == 0);
            sa = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) c = 0;
            else c = $urandom_range(m_avail(), 0);
            step(sv, sa, $urandom_range(2, 0) != 0, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
